// File: rtl/lc2k_pkg.sv
// lc2k_pkg: shared LC2K constants, arbiter state and owner encodings
package lc2k_pkg;
  localparam int WORD_W = 32;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_JALR = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_NOOP = 3'd7;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_DM   = 2'b10
  } owner_e;
endpackage

// File: rtl/lc2k_mem_arbiter.sv
// lc2k_mem_arbiter: shares one variable-latency word memory between fetch and data access
module lc2k_mem_arbiter
  import lc2k_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = WORD_W,
  parameter int STARVE_LIMIT   = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_dm_ack,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_owner,
  output logic              o_busy,
  output logic              o_timeout_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 2);
  arb_state_e        r_state;
  owner_e            r_owner;
  logic [SW-1:0]     r_starve;
  logic [WW-1:0]     r_wait;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_terr;
  logic              w_starved;
  logic              w_pick_if;
  logic              w_tmo;
  assign w_starved = 32'(r_starve) == STARVE_LIMIT;
  assign w_pick_if = i_if_req && (!i_dm_req || w_starved);
  // abort on the last allowed busy cycle so mem_req stays high exactly TIMEOUT_CYCLES cycles
  assign w_tmo     = TIMEOUT_CYCLES != 0 && 32'(r_wait) == TIMEOUT_CYCLES - 1;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_owner  <= OWN_NONE;
      r_starve <= '0;
      r_wait   <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_terr   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_if_req || i_dm_req) begin
          r_state  <= ST_BUSY;
          r_owner  <= w_pick_if ? OWN_IF : OWN_DM;
          r_we     <= !w_pick_if && i_dm_we;
          r_addr   <= w_pick_if ? i_if_addr : i_dm_addr;
          r_wdata  <= w_pick_if ? '0 : i_dm_wdata;
          r_wait   <= '0;
          r_starve <= w_pick_if ? '0 : i_if_req ? r_starve + 1'b1 : r_starve;
        end
        ST_BUSY: if (i_mem_ack) begin
          r_state <= ST_RESP;
          r_rdata <= r_we ? '0 : i_mem_rdata;
        end else if (w_tmo) begin
          r_state <= ST_RESP;
          r_rdata <= '0;
          r_terr  <= 1'b1;
        end else begin
          r_wait <= r_wait + 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_owner <= OWN_NONE;
          r_wait  <= '0;
        end
      endcase
    end
  end
  assign o_mem_req     = r_state == ST_BUSY;
  assign o_busy        = r_state != ST_IDLE;
  assign o_if_ack      = r_state == ST_RESP && r_owner == OWN_IF;
  assign o_dm_ack      = r_state == ST_RESP && r_owner == OWN_DM;
  assign o_if_rdata    = o_if_ack ? r_rdata : '0;
  assign o_dm_rdata    = o_dm_ack ? r_rdata : '0;
  assign o_mem_we      = r_we;
  assign o_mem_addr    = r_addr;
  assign o_mem_wdata   = r_wdata;
  assign o_owner       = r_owner;
  assign o_timeout_err = r_terr;
endmodule

// File: tb/tb_lc2k_mem_arbiter.sv
// tb_lc2k_mem_arbiter: randomized transaction-level check of the fetch/data memory arbiter
module tb_lc2k_mem_arbiter;
  localparam int SL = 2;
  localparam int TO = 8;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ack = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0;
  logic [31:0] dm_wdata = '0, mem_rdata = '0;
  logic        if_ack, dm_ack, mem_req, mem_we, busy, timeout_err;
  logic [31:0] if_rdata, dm_rdata, mem_wdata;
  logic [15:0] mem_addr;
  logic [1:0]  owner;
  int          n_vec = 0, n_bad = 0;
  int          starve = 0;
  logic        terr = 1'b0;
  logic [31:0] mem [256];
  int          w;
  int          order [6] = '{2, 2, 1, 2, 2, 1};
  always #5 clk = ~clk;
  lc2k_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack), .o_if_rdata(if_rdata),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_ack(dm_ack), .o_dm_rdata(dm_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_owner(owner), .o_busy(busy), .o_timeout_err(timeout_err)
  );
  assert property (@(posedge clk) disable iff (rst) (if_req && !if_ack) |=> if_req)
    else $error("FAIL if_req dropped before if_ack");
  assert property (@(posedge clk) disable iff (rst) (dm_req && !dm_ack) |=> dm_req)
    else $error("FAIL dm_req dropped before dm_ack");
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // one arbitration round from an IDLE cycle; d = backend wait cycles before mem_ack
  task automatic txn(input int d, output int win);
    logic        pick_if, we, to;
    logic [15:0] a;
    logic [31:0] wd, exp_rd;
    pick_if = if_req && (!dm_req || starve == SL);
    if (pick_if) starve = 0;
    else if (if_req) starve = starve + 1;
    a  = pick_if ? if_addr : dm_addr;
    we = !pick_if && dm_we;
    wd = dm_wdata;
    to = 1'b0;
    tick;
    for (int c = 0; ; c++) begin
      chk("busy.mem_req", mem_req, 1);
      chk("busy.mem_addr", mem_addr, a);
      chk("busy.mem_we", mem_we, we);
      if (we) chk("busy.mem_wdata", mem_wdata, wd);
      chk("busy.owner", owner, pick_if ? 2'b01 : 2'b10);
      chk("busy.acks", {if_ack, dm_ack}, 2'b00);
      mem_ack   = (c == d);
      mem_rdata = (mem_ack && !we) ? mem[a[7:0]] : $urandom;
      tick;
      if (c == d) break;
      if (c == TO - 1) begin
        to = 1'b1;
        break;
      end
    end
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    exp_rd = (to || we) ? 32'd0 : mem[a[7:0]];
    if (to) terr = 1'b1;
    else if (we) mem[a[7:0]] = wd;
    chk("resp.acks", {if_ack, dm_ack}, pick_if ? 2'b10 : 2'b01);
    chk("resp.rdata", pick_if ? if_rdata : dm_rdata, exp_rd);
    chk("resp.mem_req", mem_req, 0);
    chk("resp.busy", busy, 1);
    chk("resp.timeout_err", timeout_err, terr);
    tick;
    mem_ack = 1'b0;
    chk("idle.owner", owner, 0);
    chk("idle.busy", busy, 0);
    chk("idle.acks", {if_ack, dm_ack}, 2'b00);
    win = pick_if ? 1 : 2;
  endtask
  task automatic drop_winner(input int win);
    if (win == 1) if_req = 1'b0;
    else dm_req = 1'b0;
  endtask
  task automatic drain;
    int wn;
    while (if_req || dm_req) begin
      txn(0, wn);
      drop_winner(wn);
    end
  endtask
  initial begin
    foreach (mem[i]) mem[i] = $urandom;
    mem[5] = 32'h00C0_0000;
    tick;
    tick;
    chk("rst.mem_req", mem_req, 0);
    chk("rst.owner", owner, 0);
    chk("rst.busy", busy, 0);
    chk("rst.acks", {if_ack, dm_ack}, 2'b00);
    chk("rst.timeout_err", timeout_err, 0);
    chk("rst.mem_addr", mem_addr, 0);
    rst = 1'b0;
    tick;
    chk("idle.noreq.busy", busy, 0);
    if_req = 1'b1;
    if_addr = 16'd5;
    txn(0, w);
    chk("fetch0.win", w, 1);
    if_req = 1'b0;
    dm_req = 1'b1;
    dm_we = 1'b1;
    dm_addr = 16'd100;
    dm_wdata = 32'hDEAD_BEEF;
    txn(4, w);
    chk("sw.win", w, 2);
    dm_we = 1'b0;
    txn(TO - 1, w);
    chk("lw.boundary.timeout_err", timeout_err, 0);
    dm_req = 1'b0;
    if_req = 1'b1;
    dm_req = 1'b1;
    if_addr = 16'($urandom_range(0, 255));
    dm_addr = 16'($urandom_range(0, 255));
    for (int k = 0; k < 6; k++) begin
      txn($urandom_range(0, 2), w);
      chk("contend.order", w, order[k]);
      dm_we = 1'($urandom_range(0, 1));
      dm_wdata = $urandom;
      if (w == 1) if_addr = 16'($urandom_range(0, 255));
      else dm_addr = 16'($urandom_range(0, 255));
    end
    drain;
    if_req = 1'b1;
    if_addr = 16'd7;
    txn(100, w);
    chk("timeout.err", timeout_err, 1);
    if_addr = 16'd9;
    txn(1, w);
    chk("after_timeout.err", timeout_err, 1);
    if_req = 1'b0;
    for (int n = 0; n < 150; n++) begin
      int r;
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1'b1;
        if_addr = 16'($urandom_range(0, 255));
      end
      if (!dm_req && $urandom_range(0, 1) == 1) begin
        dm_req = 1'b1;
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = 16'($urandom_range(0, 255));
        dm_wdata = $urandom;
      end
      if (!if_req && !dm_req) begin
        mem_ack = 1'($urandom_range(0, 1));
        tick;
        mem_ack = 1'b0;
        chk("rand.idle.busy", busy, 0);
        chk("rand.idle.mem_req", mem_req, 0);
        continue;
      end
      r = $urandom_range(0, 9);
      txn(r < 7 ? r % 4 : r == 7 ? TO - 1 : r == 8 ? TO - 2 : 20, w);
      if ($urandom_range(0, 1) == 1) drop_winner(w);
      else if (w == 1) if_addr = 16'($urandom_range(0, 255));
      else begin
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = 16'($urandom_range(0, 255));
        dm_wdata = $urandom;
      end
    end
    drain;
    if_req = 1'b1;
    if_addr = 16'd33;
    tick;
    mem_ack = 1'b0;
    chk("rstbusy.mem_req1", mem_req, 1);
    tick;
    rst = 1'b1;
    if_req = 1'b0;
    tick;
    chk("rstbusy.mem_req", mem_req, 0);
    chk("rstbusy.owner", owner, 0);
    chk("rstbusy.acks", {if_ack, dm_ack}, 2'b00);
    chk("rstbusy.timeout_err", timeout_err, 0);
    rst = 1'b0;
    terr = 1'b0;
    starve = 0;
    mem_ack = 1'b1;
    mem_rdata = $urandom;
    tick;
    mem_ack = 1'b0;
    chk("stray.busy", busy, 0);
    chk("stray.acks", {if_ack, dm_ack}, 2'b00);
    tick;
    chk("stray.acks2", {if_ack, dm_ack}, 2'b00);
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_addr = 16'd100;
    txn(2, w);
    dm_req = 1'b0;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/lc2k_mem_arbiter.md
Name: lc2k_mem_arbiter

Overview:
Arbitrates one shared single-ported LC2K word memory between the IF stage (instruction fetch, read-only) and the MEM stage (LW/SW data access). The backend memory has variable latency and signals completion with mem_ack. The block sequences one backend transaction at a time, holds request fields stable, and returns a one-cycle ack with data to the winning requester. Data accesses have priority, and a starvation limit prevents fetch lockout.

Parameters:
ADDR_W, 16, word-address width; matches the 16-bit LC2K offsetField.
DATA_W, 32, word width.
STARVE_LIMIT, 3, consecutive contended data grants before fetch is forced to win; must be >= 1.
TIMEOUT_CYCLES, 64, maximum busy cycles without mem_ack before abort; 0 disables the timeout.

Ports:
clock  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
if_req  in  1  fetch request; held until if_ack.
if_addr  in  ADDR_W  fetch word address; stable while if_req is high.
if_ack  out  1  one-cycle completion pulse for fetch.
if_rdata  out  DATA_W  fetched word; valid only when if_ack is high.
dm_req  in  1  data request; held until dm_ack.
dm_we  in  1  1 = SW (write), 0 = LW (read).
dm_addr  in  ADDR_W  data word address.
dm_wdata  in  DATA_W  store data.
dm_ack  out  1  one-cycle completion pulse for data.
dm_rdata  out  DATA_W  load data; 0 for writes.
mem_req  out  1  backend request; held until mem_ack.
mem_we  out  1  backend write enable.
mem_addr  out  ADDR_W  latched address.
mem_wdata  out  DATA_W  latched write data.
mem_ack  in  1  backend completion; also qualifies mem_rdata.
mem_rdata  in  DATA_W  backend read data.
owner  out  2  00 = none, 01 = fetch, 10 = data.
busy  out  1  high whenever state != IDLE.
timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset (synchronous): every output is 0. State = IDLE, starve_cnt = 0, wait_cnt = 0, timeout_err = 0.
- States:
  - IDLE: requests are sampled only in this state.
  - BUSY: mem_req = 1, with mem_we/mem_addr/mem_wdata from registers latched at grant.
  - RESP: exactly one cycle; the owner's ack = 1 and its rdata is valid.
- IDLE transitions:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant data, unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
  - On grant: latch the request fields, set owner, go to BUSY.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) on a contended data grant.
  - Cleared on any fetch grant.
  - Unchanged on an uncontended data grant.
- BUSY transitions:
  - mem_ack = 1: capture mem_rdata (or 0 if a write) into the owner's rdata register, go to RESP.
  - Otherwise wait_cnt increments.
  - If TIMEOUT_CYCLES != 0 and wait_cnt reaches TIMEOUT_CYCLES: set timeout_err, rdata = 0, go to RESP (abort, so the pipeline does not hang).
  - mem_ack and the timeout in the same cycle: the ack wins and no error is flagged.
- RESP: ack pulses. Next state is IDLE. owner clears and wait_cnt clears. Requests are not sampled in RESP.
- Latency: request seen at cycle T → mem_req high at T+1 → with mem_ack at T+1, ack at T+2. Next grant is possible at T+3. Each added backend wait cycle adds 1.
- Requester handshake:
  - Keep req high through the ack cycle only if another transaction is wanted.
  - New address/data must be valid by the cycle after ack.
  - Deasserting req before ack is illegal; the result is undefined and flagged by assertion in the bench.
- mem_ack outside BUSY is ignored.
- mem_req falls in the RESP cycle (registered output).
- Reset in BUSY or RESP: next cycle everything is back at reset values and no ack is issued. Backend completion of an in-flight write is the backend's concern.
- timeout_err clears only on reset.

Decomposition:
- Package lc2k_pkg holds:
  - the opcode constants (ADD..NOOP, 3-bit);
  - WORD_W = 32;
  - the arbiter state encoding (IDLE/BUSY/RESP);
  - the owner encoding (OWN_NONE/OWN_IF/OWN_DM).
- Single module; no sub-module is warranted. The starvation and timeout counters stay inline.

Test Plan:
- Zero-wait fetch: reset, then if_req with if_addr = 5; backend acks the cycle mem_req rises with rdata 0x00C00000 → mem_req/mem_addr = 5/mem_we = 0 at T+1, if_ack = 1 with if_rdata = 0x00C00000 at T+2, owner back to 0 at T+3.
- Contention, STARVE_LIMIT = 2, both requests held continuously → grant order is D, D, I, D, D, I; starve_cnt clears after each I.
- SW to address 100 with wdata 0xDEADBEEF, mem_ack delayed 4 cycles → mem_req high 5 cycles with mem_addr/mem_wdata stable, a single dm_ack pulse, dm_rdata = 0.
- TIMEOUT_CYCLES = 8, fetch with no mem_ack → after 8 BUSY cycles timeout_err = 1, if_ack with if_rdata = 0. Next transaction completes normally and timeout_err stays 1 until reset.
- Reset asserted in the 2nd BUSY cycle → next cycle mem_req = 0, owner = 0, no ack. A stray mem_ack afterwards is ignored.
- mem_ack arrives in exactly the cycle wait_cnt hits TIMEOUT_CYCLES → normal completion with backend data, timeout_err stays 0.
